// File: rtl/ccip_c1_wr_arbiter_pkg.sv
// Shared types for the CCI-P c1 write arbiter: c1 Tx/Rx channel structs, requester id type
// and the mdata encode/decode helpers that carry the requester id through the fabric.
package ccip_wr_arb_pkg;

  localparam int MDATA_ID_LSB = 0;
  localparam int MAX_ID_W     = 4;

  typedef logic [MAX_ID_W-1:0] t_req_id;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h1,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'h0,
    eCL_LEN_2 = 2'h1,
    eCL_LEN_4 = 2'h3
  } t_ccip_clLen;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  // Requester id in the low id_w bits, sequence number in the remaining upper bits.
  function automatic logic [15:0] encode_mdata(input t_req_id id, input logic [15:0] seq,
                                               input int id_w);
    logic [15:0] mask;
    mask = (16'd1 << id_w) - 16'd1;
    return ((seq << id_w) & ~mask) | (({12'd0, id} << MDATA_ID_LSB) & mask);
  endfunction

  function automatic t_req_id decode_mdata_id(input logic [15:0] mdata, input int id_w);
    logic [15:0] mask;
    mask = (16'd1 << id_w) - 16'd1;
    return t_req_id'((mdata >> MDATA_ID_LSB) & mask);
  endfunction

endpackage

// File: rtl/ccip_c1_wr_arbiter_if.sv
// Requester-side bundle of the c1 write arbiter: per-requester request bus, grant and ack.
interface ccip_c1_wr_arbiter_if #(
  parameter int N_REQ = 4
);
  // Handshake: requester i transfers one line on a rising edge where req_valid[i] & req_ready[i];
  // req_ready is one-hot or zero and may depend combinationally on req_valid in the same cycle.
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*42-1:0]  req_addr;
  logic [N_REQ*512-1:0] req_data;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ-1:0]     wr_ack;

  modport master (output req_valid, req_addr, req_data, input req_ready, wr_ack);
  modport slave  (input req_valid, req_addr, req_data, output req_ready, wr_ack);
endinterface

// File: rtl/ccip_c1_wr_arbiter_rr.sv
// Round-robin arbiter: first requester at or above the pointer wins, pointer moves past the
// winner only when the grant is consumed.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o
);

  logic [PW-1:0] ptr_q, ptr_d, win;
  logic          found;

  always_comb begin
    gnt_o = '0;
    win   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (PW'(i) >= ptr_q)) begin
        gnt_o[i] = 1'b1;
        win      = PW'(i);
        found    = 1'b1;
      end
    end
    // Wrap-around pass: only requesters below the pointer can still win here.
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        win      = PW'(i);
        found    = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (win == PW'(N - 1)) ? '0 : win + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ccip_c1_wr_arbiter.sv
// Shares the CCI-P c1 write channel between N_REQ requesters: round-robin grant, id in mdata,
// per-requester outstanding tracking and ack routing of write responses.
module ccip_c1_wr_arbiter
  import ccip_wr_arb_pkg::*;
#(
  parameter  int N_REQ           = 4,
  parameter  int MAX_OUTSTANDING = 64,
  localparam int ID_W            = $clog2(N_REQ),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                 Clk_400,
  input  logic                 SoftReset,
  ccip_c1_wr_arbiter_if.slave  req,
  input  logic                 c1TxAlmFull,
  output t_if_ccip_c1_Tx       sTxC1,
  input  t_if_ccip_c1_Rx       sRxC1,
  output logic                 idle,
  output logic                 err_unexp_rsp
);

  localparam int SEQ_W = 16 - ID_W;

  logic [N_REQ-1:0] eligible, arb_req, gnt, rsp_dec;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [SEQ_W-1:0] seq_q;
  t_if_ccip_c1_Tx   tx_q, tx_d;
  logic             idle_q, err_q, err_d, all_zero, transfer;
  logic [ID_W-1:0]  win_id;
  logic [41:0]      win_addr;
  logic [511:0]     win_data;
  logic             rsp_hit, rsp_oob;
  t_req_id          rsp_id;
  logic             unused_rx;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req.req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
    arb_req = (c1TxAlmFull || SoftReset) ? '0 : eligible;
  end

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk_i     (Clk_400),
    .rst_i     (SoftReset),
    .req_i     (arb_req),
    .advance_i (transfer),
    .gnt_o     (gnt)
  );

  assign transfer      = |gnt;
  assign req.req_ready = gnt;

  always_comb begin
    win_id   = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_id   = ID_W'(i);
        win_addr = req.req_addr[42*i +: 42];
        win_data = req.req_data[512*i +: 512];
      end
    end
    tx_d                 = '0;
    tx_d.valid           = transfer;
    tx_d.hdr.req_type    = eREQ_WRLINE_I;
    tx_d.hdr.vc_sel      = eVC_VA;
    tx_d.hdr.cl_len      = eCL_LEN_1;
    tx_d.hdr.sop         = 1'b1;
    tx_d.hdr.address     = win_addr;
    tx_d.hdr.mdata       = encode_mdata(t_req_id'(win_id), 16'(seq_q), ID_W);
    tx_d.data            = win_data;
  end

  // Fields the arbiter does not need; single-line responses are assumed.
  assign unused_rx = ^{sRxC1.hdr.vc_used, sRxC1.hdr.rsvd1, sRxC1.hdr.hit_miss,
                       sRxC1.hdr.format, sRxC1.hdr.rsvd0, sRxC1.hdr.cl_num};

  assign rsp_hit = sRxC1.rspValid && (sRxC1.hdr.resp_type == eRSP_WRLINE);
  assign rsp_id  = decode_mdata_id(sRxC1.hdr.mdata, ID_W);
  assign rsp_oob = int'(rsp_id) >= N_REQ;

  // A response against an empty counter is a stray (e.g. after SoftReset): flag it, never ack it.
  always_comb begin
    err_d    = err_q | (rsp_hit && rsp_oob);
    ack_d    = '0;
    all_zero = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_dec[i] = rsp_hit && !rsp_oob && (rsp_id == t_req_id'(i));
      cnt_d[i]   = cnt_q[i];
      if (gnt[i] && !rsp_dec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!gnt[i] && rsp_dec[i]) begin
        if (cnt_q[i] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
          ack_d[i] = 1'b1;
        end
      end else if (gnt[i] && rsp_dec[i]) begin
        ack_d[i] = 1'b1;
      end
      if (cnt_q[i] != '0) all_zero = 1'b0;
    end
  end

  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      tx_q   <= '0;
      ack_q  <= '0;
      seq_q  <= '0;
      idle_q <= 1'b1;
      err_q  <= 1'b0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      tx_q   <= tx_d;
      ack_q  <= ack_d;
      idle_q <= all_zero;
      err_q  <= err_d;
      if (transfer) seq_q <= seq_q + SEQ_W'(1);
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sTxC1         = tx_q;
  assign req.wr_ack    = ack_q;
  assign idle          = idle_q;
  assign err_unexp_rsp = err_q;

endmodule

// File: tb/tb_ccip_c1_wr_arbiter.sv
// Directed bench for ccip_c1_wr_arbiter (N_REQ=4, MAX_OUTSTANDING=4) with hand-computed expectations.
module tb_ccip_c1_wr_arbiter;
  import ccip_wr_arb_pkg::*;

  localparam int N_REQ   = 4;
  localparam int MAX_OUT = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           almfull;
  t_if_ccip_c1_Tx tx;
  t_if_ccip_c1_Rx rx;
  logic           idle;
  logic           err;
  int             checks = 0;
  int             errors = 0;
  int             exp_id;
  int             n_tx;

  ccip_c1_wr_arbiter_if #(.N_REQ(N_REQ)) rif ();

  ccip_c1_wr_arbiter #(.N_REQ(N_REQ), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .Clk_400       (clk),
    .SoftReset     (rst),
    .req           (rif),
    .c1TxAlmFull   (almfull),
    .sTxC1         (tx),
    .sRxC1         (rx),
    .idle          (idle),
    .err_unexp_rsp (err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int i, input logic v, input logic [41:0] a, input logic [511:0] d);
    rif.req_valid[i]            = v;
    rif.req_addr[42*i +: 42]    = a;
    rif.req_data[512*i +: 512]  = d;
  endtask

  task automatic drive_rsp(input t_ccip_c1_rsp t, input logic [15:0] m);
    rx               = '0;
    rx.rspValid      = 1'b1;
    rx.hdr.resp_type = t;
    rx.hdr.mdata     = m;
  endtask

  task automatic rsp_pulse(input string tag, input logic [15:0] m, input logic [3:0] exp_ack);
    drive_rsp(eRSP_WRLINE, m);
    step();
    rx = '0;
    chk(tag, rif.wr_ack, exp_ack);
  endtask

  initial begin
    rst           = 1'b1;
    almfull       = 1'b0;
    rx            = '0;
    rif.req_valid = '0;
    rif.req_addr  = '0;
    rif.req_data  = '0;
    repeat (2) step();

    // reset state, with a request pending to show grants are held off
    set_req(0, 1'b1, 42'h100, {64{8'hA5}});
    #1;
    chk("rst_tx_valid", tx.valid, 0);
    chk("rst_ready", rif.req_ready, 0);
    chk("rst_ack", rif.wr_ack, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);

    // single requester
    rst = 1'b0;
    #1;
    chk("t1_ready", rif.req_ready, 4'b0001);
    step();
    set_req(0, 1'b0, 42'h100, {64{8'hA5}});
    chk("t1_tx_valid", tx.valid, 1);
    chk("t1_addr", tx.hdr.address, 42'h100);
    chk("t1_mdata", tx.hdr.mdata, 16'h0000);
    chk("t1_data", tx.data == {64{8'hA5}}, 1);
    chk("t1_type", tx.hdr.req_type, eREQ_WRLINE_I);
    chk("t1_sop", tx.hdr.sop, 1);
    chk("t1_idle_lag", idle, 1);
    step();
    chk("t1_tx_idle", tx.valid, 0);
    chk("t1_busy", idle, 0);
    repeat (8) step();
    rsp_pulse("t1_ack", 16'h0000, 4'b0001);
    chk("t1_idle_still0", idle, 0);
    step();
    chk("t1_ack_once", rif.wr_ack, 0);
    chk("t1_idle_back", idle, 1);

    // fairness: pointer sits at 1 after the single grant to requester 0
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 42'h1000 + 42'(i), {16{32'(i)}});
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_id = (1 + k) % N_REQ;
      chk("t2_ready", rif.req_ready, 64'd1 << exp_id);
      step();
      chk("t2_addr", tx.hdr.address, 42'h1000 + 42'(exp_id));
      chk("t2_id_tag", tx.hdr.mdata[1:0], tx.hdr.address[1:0]);
      chk("t2_mdata", tx.hdr.mdata, 64'(((1 + k) << 2) | exp_id));
    end
    rif.req_valid = '0;
    #1;

    // backpressure: outstanding now 2/2/2/2
    rif.req_valid = 4'b1010;
    #1;
    chk("t3_ready_pre", rif.req_ready, 4'b0010);
    step();
    almfull = 1'b1;
    #1;
    n_tx = 0;
    for (int k = 0; k < 20; k++) begin
      chk("t3_ready_af", rif.req_ready, 0);
      if (tx.valid) n_tx++;
      step();
    end
    chk("t3_tx_after_af", n_tx, 1);
    almfull = 1'b0;
    #1;
    chk("t3_resume", rif.req_ready, 4'b1000);
    step();
    chk("t3_resume_id", tx.hdr.mdata[1:0], 3);
    rif.req_valid = '0;

    // outstanding cap: requester 1 holds 3, one more fills it
    rif.req_valid = 4'b0010;
    #1;
    chk("t4_ready_last", rif.req_ready, 4'b0010);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("t4_stall", rif.req_ready, 0);
      step();
    end
    rsp_pulse("t4_ack", 16'h0041, 4'b0010);
    chk("t4_reenable", rif.req_ready, 4'b0010);
    step();
    chk("t4_one_more_tx", tx.valid, 1);
    for (int k = 0; k < 4; k++) begin
      chk("t4_stall_again", rif.req_ready, 0);
      step();
    end
    rif.req_valid = '0;

    // simultaneous transfer and response for requester 2 (outstanding 2/4/2/3)
    rif.req_valid = 4'b0100;
    drive_rsp(eRSP_WRLINE, 16'h0082);
    #1;
    chk("t5_ready", rif.req_ready, 4'b0100);
    step();
    rif.req_valid = '0;
    rx = '0;
    chk("t5_ack", rif.wr_ack, 4'b0100);
    chk("t5_busy", idle, 0);
    rsp_pulse("t5_drain0", 16'h0000, 4'b0001);
    rsp_pulse("t5_drain0", 16'h0004, 4'b0001);
    for (int k = 0; k < 4; k++) rsp_pulse("t5_drain1", 16'h0001, 4'b0010);
    rsp_pulse("t5_drain2", 16'h0002, 4'b0100);
    rsp_pulse("t5_drain2", 16'h0006, 4'b0100);
    for (int k = 0; k < 3; k++) rsp_pulse("t5_drain3", 16'h0003, 4'b1000);
    step();
    chk("t5_idle", idle, 1);
    chk("t5_no_err", err, 0);
    drive_rsp(eRSP_WRFENCE, 16'h0000);
    step();
    rx = '0;
    chk("t5_fence_ack", rif.wr_ack, 0);
    chk("t5_fence_err", err, 0);
    rsp_pulse("t5_id5_ack", 16'h0005, 4'b0000);
    chk("t5_id5_err", err, 1);

    // reset mid-flight
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_err_clr", err, 0);
    rif.req_valid = 4'b0001;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t6_ready", rif.req_ready, 4'b0001);
      step();
    end
    chk("t6_inflight", tx.valid, 1);
    rst = 1'b1;
    rif.req_valid = 4'b1111;
    #1;
    chk("t6_ready_rst", rif.req_ready, 0);
    step();
    chk("t6_tx_dropped", tx.valid, 0);
    chk("t6_idle_rst", idle, 1);
    rst = 1'b0;
    rif.req_valid = '0;
    for (int k = 0; k < 3; k++) rsp_pulse("t6_late_ack", 16'(k << 2), 4'b0000);
    step();
    chk("t6_err", err, 1);
    chk("t6_idle", idle, 1);
    rif.req_valid = 4'b1111;
    #1;
    chk("t6_next_grant", rif.req_ready, 4'b0001);
    step();
    rif.req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
